// File: rtl/ddr3_phy_pkg.sv
// Shared types and constants for the DDR3 PHY write-data launch path.
package ddr3_phy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_DATA0 = 3'd2,
    ST_DATA1 = 3'd3,
    ST_DATA2 = 3'd4,
    ST_DATA3 = 3'd5,
    ST_POST  = 3'd6
  } wr_state_t;

  localparam int BL8_CYCLES  = 4;
  localparam int WR_LAT_MIN  = 2;
  localparam int WR_LAT_MAX  = 15;
  localparam int SCHED_DEPTH = WR_LAT_MAX + 1;

  localparam logic IDLE_OEN  = 1'b1;
  localparam logic IDLE_DATA = 1'b0;

  function automatic logic is_data(input wr_state_t s);
    return (s == ST_DATA0) || (s == ST_DATA1) || (s == ST_DATA2) || (s == ST_DATA3);
  endfunction

  // Position of the beat being accepted while the FSM drives state s.
  function automatic logic [1:0] beat_slot(input wr_state_t s);
    case (s)
      ST_DATA0: return 2'd1;
      ST_DATA1: return 2'd2;
      ST_DATA2: return 2'd3;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ddr3_wr_sched_sr.sv
// Write-request scheduler: a shift register of sampled WRITE commands that flags
// when a preamble or a first data beat must be launched for the configured latency.
module ddr3_wr_sched_sr
  import ddr3_phy_pkg::*;
(
  input  logic       clk_x1,
  input  logic       reset,
  input  logic       i_req,
  input  logic [3:0] i_cfg_wr_lat,
  output logic       o_pre_due,
  output logic       o_start_due,
  output logic       o_pend_next
);

  logic [SCHED_DEPTH-1:0] r_sr;
  logic [SCHED_DEPTH-1:0] w_pre_sel;
  logic [SCHED_DEPTH-1:0] w_start_sel;
  logic [SCHED_DEPTH-1:0] w_pend_mask;
  logic [4:0]             w_lat;

  assign w_lat = {1'b0, i_cfg_wr_lat};

  // Bit k holds a request sampled k+1 edges ago; taps are one-hot selects on the latency.
  generate
    for (genvar gi = 0; gi < SCHED_DEPTH; gi++) begin : g_tap
      assign w_pre_sel[gi]   = (w_lat == 5'(gi + WR_LAT_MIN));
      assign w_pend_mask[gi] = (w_lat >= 5'(gi + WR_LAT_MIN));
      if (gi + 1 >= WR_LAT_MIN) begin : g_start
        assign w_start_sel[gi] = (w_lat == 5'(gi + 1));
      end else begin : g_nostart
        assign w_start_sel[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk_x1) begin
    if (reset) begin
      r_sr <= '0;
    end else begin
      r_sr <= {r_sr[SCHED_DEPTH-2:0], i_req};
    end
  end

  assign o_pre_due   = |(r_sr & w_pre_sel);
  assign o_start_due = |(r_sr & w_start_sel);
  assign o_pend_next = |(r_sr & w_pend_mask);

endmodule

// File: rtl/ddr3_wr_dq_launch.sv
// DDR3 write-data launch: turns WRITE commands plus a beat stream into DQ/DQS/DM IOB drive.
// Optional DM drive from s_mask is enabled by defining DDR3_WR_DM_EN.
module ddr3_wr_dq_launch
  import ddr3_phy_pkg::*;
#(
  parameter int DQ_WIDTH = 16,
  parameter int DM_WIDTH = DQ_WIDTH / 8
) (
  input  logic                  clk_x1,
  input  logic                  reset,
  input  logic [3:0]            i_cfg_wr_lat,
  input  logic                  i_wr_req,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic                  i_s_last,
  input  logic [2*DQ_WIDTH-1:0] i_s_data,
  input  logic [2*DM_WIDTH-1:0] i_s_mask,
  output logic                  o_dq_oen,
  output logic [DQ_WIDTH-1:0]   o_dq_d0,
  output logic [DQ_WIDTH-1:0]   o_dq_d1,
  output logic                  o_dqs_oen,
  output logic [DM_WIDTH-1:0]   o_dqs_d0,
  output logic [DM_WIDTH-1:0]   o_dqs_d1,
  output logic [DM_WIDTH-1:0]   o_dm_d0,
  output logic [DM_WIDTH-1:0]   o_dm_d1,
  output logic                  o_busy,
  input  logic                  i_err_clr,
  output logic                  o_err_underrun,
  output logic                  o_err_last,
  output logic                  o_err_collide
);

  wr_state_t             r_state, w_state_next;
  logic                  r_armed, w_armed_next;
  logic                  r_s_ready, r_busy;
  logic                  r_dq_oen, r_dqs_oen;
  logic [DQ_WIDTH-1:0]   r_dq_d0, r_dq_d1;
  logic [DM_WIDTH-1:0]   r_dqs_d0;
  logic                  r_err_underrun, r_err_last, r_err_collide;

  logic w_lat_ok, w_req_acc, w_req_bad;
  logic w_pre_due, w_start_due, w_start_ok, w_pend_next;
  logic w_col_pre, w_col_start;
  logic w_ready_next, w_busy_next;
  logic w_last_pos, w_set_underrun, w_set_last, w_set_collide;

  assign w_lat_ok  = (i_cfg_wr_lat >= 4'(WR_LAT_MIN));
  assign w_req_acc = i_wr_req && w_lat_ok;
  assign w_req_bad = i_wr_req && !w_lat_ok;

  ddr3_wr_sched_sr u_sched (
    .clk_x1      (clk_x1),
    .reset       (reset),
    .i_req       (w_req_acc),
    .i_cfg_wr_lat(i_cfg_wr_lat),
    .o_pre_due   (w_pre_due),
    .o_start_due (w_start_due),
    .o_pend_next (w_pend_next)
  );

  // r_armed marks a scheduled start whose preamble (or seamless slot) was granted;
  // starts of dropped requests arrive unarmed and are ignored.
  assign w_start_ok = w_start_due && r_armed;

  always_comb begin
    w_state_next = r_state;
    w_armed_next = r_armed;
    w_col_pre    = 1'b0;
    w_col_start  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pre_due) begin
          w_state_next = ST_PRE;
          w_armed_next = 1'b1;
        end
      end
      ST_PRE: begin
        w_col_pre    = w_pre_due;
        w_armed_next = 1'b0;
        w_state_next = w_start_ok ? ST_DATA0 : ST_IDLE;
      end
      ST_DATA0: begin
        w_state_next = ST_DATA1;
        w_col_pre    = w_pre_due;
        w_col_start  = w_start_due;
      end
      ST_DATA1: begin
        w_state_next = ST_DATA2;
        w_col_pre    = w_pre_due;
        w_col_start  = w_start_due;
      end
      ST_DATA2: begin
        // A preamble due now belongs to a request exactly one burst behind: chain it.
        w_state_next = ST_DATA3;
        w_col_start  = w_start_due;
        if (w_pre_due) w_armed_next = 1'b1;
      end
      ST_DATA3: begin
        w_col_pre = w_pre_due;
        if (w_start_ok) begin
          w_state_next = ST_DATA0;
          w_armed_next = 1'b0;
        end else begin
          w_state_next = ST_POST;
        end
      end
      ST_POST: begin
        if (w_pre_due) begin
          w_state_next = ST_PRE;
          w_armed_next = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_armed_next = 1'b0;
      end
    endcase
  end

  assign w_ready_next = (w_state_next == ST_PRE) || (w_state_next == ST_DATA0) ||
                        (w_state_next == ST_DATA1) || (w_state_next == ST_DATA2) ||
                        ((w_state_next == ST_DATA3) && w_armed_next);
  assign w_busy_next  = w_req_acc || w_pend_next || (w_state_next != ST_IDLE);

  assign w_last_pos     = (beat_slot(r_state) == 2'(BL8_CYCLES - 1));
  assign w_set_underrun = r_s_ready && !i_s_valid;
  assign w_set_last     = r_s_ready && i_s_valid && (i_s_last != w_last_pos);
  assign w_set_collide  = w_col_pre || w_col_start || w_req_bad;

  always_ff @(posedge clk_x1) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_armed        <= 1'b0;
      r_s_ready      <= 1'b0;
      r_busy         <= 1'b0;
      r_dq_oen       <= IDLE_OEN;
      r_dqs_oen      <= IDLE_OEN;
      r_dq_d0        <= {DQ_WIDTH{IDLE_DATA}};
      r_dq_d1        <= {DQ_WIDTH{IDLE_DATA}};
      r_dqs_d0       <= {DM_WIDTH{IDLE_DATA}};
      r_err_underrun <= 1'b0;
      r_err_last     <= 1'b0;
      r_err_collide  <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_armed        <= w_armed_next;
      r_s_ready      <= w_ready_next;
      r_busy         <= w_busy_next;
      r_dq_oen       <= ~is_data(w_state_next);
      r_dqs_oen      <= (w_state_next == ST_IDLE);
      r_dqs_d0       <= {DM_WIDTH{is_data(w_state_next)}};
      if (r_s_ready && i_s_valid) begin
        r_dq_d0 <= i_s_data[DQ_WIDTH-1:0];
        r_dq_d1 <= i_s_data[2*DQ_WIDTH-1:DQ_WIDTH];
      end else begin
        r_dq_d0 <= {DQ_WIDTH{IDLE_DATA}};
        r_dq_d1 <= {DQ_WIDTH{IDLE_DATA}};
      end
      r_err_underrun <= (r_err_underrun && !i_err_clr) || w_set_underrun;
      r_err_last     <= (r_err_last && !i_err_clr) || w_set_last;
      r_err_collide  <= (r_err_collide && !i_err_clr) || w_set_collide;
    end
  end

`ifdef DDR3_WR_DM_EN
  logic [DM_WIDTH-1:0] r_dm_d0, r_dm_d1;

  // Underrun slots are fully masked so the DRAM keeps the old bytes.
  always_ff @(posedge clk_x1) begin
    if (reset) begin
      r_dm_d0 <= {DM_WIDTH{IDLE_DATA}};
      r_dm_d1 <= {DM_WIDTH{IDLE_DATA}};
    end else if (r_s_ready) begin
      if (i_s_valid) begin
        r_dm_d0 <= i_s_mask[DM_WIDTH-1:0];
        r_dm_d1 <= i_s_mask[2*DM_WIDTH-1:DM_WIDTH];
      end else begin
        r_dm_d0 <= '1;
        r_dm_d1 <= '1;
      end
    end else begin
      r_dm_d0 <= {DM_WIDTH{IDLE_DATA}};
      r_dm_d1 <= {DM_WIDTH{IDLE_DATA}};
    end
  end

  assign o_dm_d0 = r_dm_d0;
  assign o_dm_d1 = r_dm_d1;
`else
  logic w_unused_mask;
  assign w_unused_mask = ^i_s_mask;
  assign o_dm_d0       = {DM_WIDTH{IDLE_DATA}};
  assign o_dm_d1       = {DM_WIDTH{IDLE_DATA}};
`endif

  assign o_s_ready      = r_s_ready;
  assign o_busy         = r_busy;
  assign o_dq_oen       = r_dq_oen;
  assign o_dq_d0        = r_dq_d0;
  assign o_dq_d1        = r_dq_d1;
  assign o_dqs_oen      = r_dqs_oen;
  assign o_dqs_d0       = r_dqs_d0;
  assign o_dqs_d1       = {DM_WIDTH{IDLE_DATA}};
  assign o_err_underrun = r_err_underrun;
  assign o_err_last     = r_err_last;
  assign o_err_collide  = r_err_collide;

endmodule

// File: tb/tb_ddr3_wr_dq_launch.sv
// Scoreboard bench for ddr3_wr_dq_launch: expected data cycles are queued at issue time
// and popped by a monitor whenever the DUT enables DQ.
module tb_ddr3_wr_dq_launch;

`ifdef DDR3_WR_DM_EN
  localparam bit DM_EN = 1'b1;
`else
  localparam bit DM_EN = 1'b0;
`endif

  logic        clk_x1 = 1'b0;
  logic        reset;
  logic [3:0]  i_cfg_wr_lat;
  logic        i_wr_req, i_s_valid, i_s_last, i_err_clr;
  logic [31:0] i_s_data;
  logic [3:0]  i_s_mask;
  logic        o_s_ready, o_dq_oen, o_dqs_oen, o_busy;
  logic [15:0] o_dq_d0, o_dq_d1;
  logic [1:0]  o_dqs_d0, o_dqs_d1, o_dm_d0, o_dm_d1;
  logic        o_err_underrun, o_err_last, o_err_collide;

  ddr3_wr_dq_launch #(.DQ_WIDTH(16), .DM_WIDTH(2)) dut (
    .clk_x1(clk_x1), .reset(reset), .i_cfg_wr_lat(i_cfg_wr_lat), .i_wr_req(i_wr_req),
    .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .i_s_last(i_s_last), .i_s_data(i_s_data),
    .i_s_mask(i_s_mask), .o_dq_oen(o_dq_oen), .o_dq_d0(o_dq_d0), .o_dq_d1(o_dq_d1),
    .o_dqs_oen(o_dqs_oen), .o_dqs_d0(o_dqs_d0), .o_dqs_d1(o_dqs_d1), .o_dm_d0(o_dm_d0),
    .o_dm_d1(o_dm_d1), .o_busy(o_busy), .i_err_clr(i_err_clr), .o_err_underrun(o_err_underrun),
    .o_err_last(o_err_last), .o_err_collide(o_err_collide)
  );

  always #5 clk_x1 = ~clk_x1;

  int cyc = 0;
  always @(posedge clk_x1) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic        last;
    logic [31:0] data;
    logic [3:0]  mask;
  } beat_t;

  typedef struct {
    int          cyc;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  dm0;
    logic [1:0]  dm1;
  } exp_t;

  beat_t beat_q[$];
  exp_t  exp_q[$];
  beat_t b;
  exp_t  e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Beat source: presents the next queued beat whenever the DUT is ready.
  always @(negedge clk_x1) begin
    if (o_s_ready && beat_q.size() > 0) begin
      b = beat_q.pop_front();
      i_s_valid = b.valid;
      i_s_last  = b.last;
      i_s_data  = b.data;
      i_s_mask  = b.mask;
    end else begin
      i_s_valid = 1'b0;
      i_s_last  = 1'b0;
      i_s_data  = '0;
      i_s_mask  = '0;
    end
  end

  // Monitor: every DQ-enabled cycle must match the next expected beat.
  always @(negedge clk_x1) begin
    if (o_dq_oen === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_data: DQ driven at cycle %0d, none expected", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("data_cycle", cyc, e.cyc);
        chk("dq_d0", {16'h0, o_dq_d0}, {16'h0, e.d0});
        chk("dq_d1", {16'h0, o_dq_d1}, {16'h0, e.d1});
        chk("dm", {28'h0, o_dm_d1, o_dm_d0}, {28'h0, e.dm1, e.dm0});
        chk("dqs_data", {27'h0, o_dqs_oen, o_dqs_d0, o_dqs_d1}, {27'h0, 1'b0, 2'b11, 2'b00});
      end
    end
  end

  task automatic at(input int t);
    while (cyc < t) @(negedge clk_x1);
    checks++;
    if (cyc != t) begin
      errors++;
      $display("FAIL timing: at cycle %0d, wanted %0d", cyc, t);
    end
  endtask

  task automatic pulse_req(input int t);
    at(t - 1);
    i_wr_req = 1'b1;
    at(t);
    i_wr_req = 1'b0;
  endtask

  task automatic clear_errs();
    i_err_clr = 1'b1;
    at(cyc + 1);
    i_err_clr = 1'b0;
    chk("errs_cleared", {29'h0, o_err_collide, o_err_last, o_err_underrun}, 32'h0);
  endtask

  // Beat k: d0 = seed^(k*0x1111), d1 = seed^((k+1)*0x1111); ur = underrun slot, lastk = s_last slot.
  task automatic push_burst(input int t, input int lat, input logic [15:0] seed, input logic [3:0] mseed,
                            input int ur, input int lastk, input int nbeats, input int nexp);
    beat_t bb;
    exp_t  ee;
    for (int k = 0; k < 4; k++) begin
      logic [15:0] d0, d1;
      logic [3:0]  m;
      d0 = seed ^ 16'(k * 32'h1111);
      d1 = seed ^ 16'((k + 1) * 32'h1111);
      m  = mseed ^ 4'(k + 1);
      if (k < nbeats) begin
        bb.valid = (k != ur);
        bb.last  = (k == lastk);
        bb.data  = {d1, d0};
        bb.mask  = m;
        beat_q.push_back(bb);
      end
      if (k < nexp) begin
        ee.cyc = t + lat + k;
        if (k == ur) begin
          ee.d0  = 16'h0;
          ee.d1  = 16'h0;
          ee.dm0 = DM_EN ? 2'b11 : 2'b00;
          ee.dm1 = DM_EN ? 2'b11 : 2'b00;
        end else begin
          ee.d0  = d0;
          ee.d1  = d1;
          ee.dm0 = DM_EN ? m[1:0] : 2'b00;
          ee.dm1 = DM_EN ? m[3:2] : 2'b00;
        end
        exp_q.push_back(ee);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    reset        = 1'b1;
    i_cfg_wr_lat = 4'd5;
    i_wr_req     = 1'b0;
    i_err_clr    = 1'b0;
    i_s_valid    = 1'b0;
    i_s_last     = 1'b0;
    i_s_data     = '0;
    i_s_mask     = '0;

    at(3);
    chk("reset_ctrl", {28'h0, o_dq_oen, o_dqs_oen, o_s_ready, o_busy}, 32'hC);
    chk("reset_data", {o_dq_d0, o_dq_d1}, 32'h0);
    chk("reset_dqs_dm", {24'h0, o_dqs_d0, o_dqs_d1, o_dm_d0, o_dm_d1}, 32'h0);
    chk("reset_errs", {29'h0, o_err_collide, o_err_last, o_err_underrun}, 32'h0);
    reset = 1'b0;

    // Single burst, L=5, T=10
    t = 10;
    push_burst(t, 5, 16'h0000, 4'h0, -1, 3, 4, 4);
    pulse_req(t);
    chk("t1_busy_at_T", {31'h0, o_busy}, 32'h1);
    at(t + 4);
    chk("t1_pre", {27'h0, o_dq_oen, o_dqs_oen, o_dqs_d0, o_s_ready}, {27'h0, 1'b1, 1'b0, 2'b00, 1'b1});
    at(t + 9);
    chk("t1_post", {28'h0, o_dq_oen, o_dqs_oen, o_dqs_d0}, {28'h0, 1'b1, 1'b0, 2'b00});
    at(t + 10);
    chk("t1_idle", {28'h0, o_dq_oen, o_dqs_oen, o_busy, o_s_ready}, 32'hC);
    chk("t1_errs", {29'h0, o_err_collide, o_err_last, o_err_underrun}, 32'h0);

    // Seamless pair, requests 4 apart
    t = 30;
    push_burst(t, 5, 16'h0000, 4'h0, -1, 3, 4, 4);
    push_burst(t + 4, 5, 16'hA5A5, 4'h9, -1, 3, 4, 4);
    pulse_req(t);
    pulse_req(t + 4);
    at(t + 13);
    chk("t2_post", {29'h0, o_dq_oen, o_dqs_oen, o_busy}, 32'h5);
    at(t + 14);
    chk("t2_idle", {29'h0, o_dq_oen, o_dqs_oen, o_busy}, 32'h6);
    chk("t2_errs", {29'h0, o_err_collide, o_err_last, o_err_underrun}, 32'h0);

    // Collision: second request 2 cycles later is dropped
    t = 60;
    push_burst(t, 5, 16'h0F0F, 4'h6, -1, 3, 4, 4);
    pulse_req(t);
    pulse_req(t + 2);
    at(t + 10);
    chk("t3_errs", {29'h0, o_err_collide, o_err_last, o_err_underrun}, 32'h4);
    chk("t3_idle", {30'h0, o_dqs_oen, o_busy}, 32'h2);
    clear_errs();

    // Underrun on the third beat
    t = 90;
    push_burst(t, 5, 16'h3C3C, 4'h5, 2, 3, 4, 4);
    pulse_req(t);
    at(t + 10);
    chk("t4_errs", {29'h0, o_err_collide, o_err_last, o_err_underrun}, 32'h1);
    chk("t4_idle", {30'h0, o_dqs_oen, o_busy}, 32'h2);
    clear_errs();

    // s_last on the second beat
    t = 120;
    push_burst(t, 5, 16'h5A5A, 4'hC, -1, 1, 4, 4);
    pulse_req(t);
    at(t + 10);
    chk("t5_errs", {29'h0, o_err_collide, o_err_last, o_err_underrun}, 32'h2);
    clear_errs();

    // Illegal latency: request ignored, collision flagged
    t = 140;
    i_cfg_wr_lat = 4'd1;
    pulse_req(t);
    chk("t7_errs", {29'h0, o_err_collide, o_err_last, o_err_underrun}, 32'h4);
    chk("t7_busy", {31'h0, o_busy}, 32'h0);
    at(t + 6);
    chk("t7_idle", {30'h0, o_dqs_oen, o_s_ready}, 32'h2);
    i_cfg_wr_lat = 4'd2;
    clear_errs();

    // Reset during DATA1 at L=2, then a normal request
    t = 160;
    push_burst(t, 2, 16'hC3C3, 4'h3, -1, 3, 3, 2);
    pulse_req(t);
    at(t + 3);
    #1 reset = 1'b1;
    at(t + 4);
    chk("t6_reset", {28'h0, o_dq_oen, o_dqs_oen, o_s_ready, o_busy}, 32'hC);
    reset = 1'b0;
    t = 167;
    push_burst(t, 2, 16'h9696, 4'hA, -1, 3, 4, 4);
    pulse_req(t);
    at(t + 1);
    chk("t6_pre", {29'h0, o_dq_oen, o_dqs_oen, o_s_ready}, 32'h5);
    at(t + 6);
    chk("t6_post", {30'h0, o_dq_oen, o_dqs_oen}, 32'h2);
    at(t + 7);
    chk("t6_idle", {29'h0, o_dq_oen, o_dqs_oen, o_busy}, 32'h6);
    chk("t6_errs", {29'h0, o_err_collide, o_err_last, o_err_underrun}, 32'h0);

    at(t + 10);
    chk("exp_queue_drained", exp_q.size(), 32'h0);
    chk("beat_queue_drained", beat_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
